divu_sequencer: RTL and testbench
=================================

// Module: divu_sequencer
// PURPOSE
//  Sequences the multi-cycle unsigned divider beside the EX stage of the 5-stage pipeline.
//  Latches DIVU operands from EX, issues a one-cycle start to the divider, and counts its latency.
//  Captures {remainder, quotient} into architectural HI/LO and stalls dependent ID instructions
//  (mfhi/mflo/divu) until the result is in place; a zero divisor is resolved without the divider.
// PARAMETERS
//  WIDTH    32  operand / HI / LO width
//  LATENCY  33  cycles from div_start pulse to div_result valid (>=1)
// PORTS
//  clk         in   1        rising-edge clock
//  rst         in   1        asynchronous, active-low reset
//  ex_divu     in   1        DIVU valid in EX this cycle
//  ex_rs_val   in   WIDTH    dividend (EX rd1)
//  ex_rt_val   in   WIDTH    divisor (EX rd2)
//  id_mf_hi    in   1        instruction in ID reads HI
//  id_mf_lo    in   1        instruction in ID reads LO
//  id_divu     in   1        instruction in ID is DIVU
//  div_start   out  1        one-cycle start pulse to divider
//  div_a       out  WIDTH    latched dividend to divider
//  div_b       out  WIDTH    latched divisor to divider
//  div_result  in   2*WIDTH  divider output {rem[63:32], quot[31:0]}
//  stall       out  1        hold PC and IF/ID, bubble into ID/EX
//  busy        out  1        state != IDLE
//  hilo_we     out  1        one-cycle pulse, HI/LO updated
//  hi          out  WIDTH    HI register (remainder)
//  lo          out  WIDTH    LO register (quotient)
//  dbz         out  1        sticky divide-by-zero flag
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, cnt=0; all outputs 0 (div_start, div_a, div_b, hi, lo,
//   hilo_we, dbz, busy); stall=0. Reset mid-RUN aborts the divide; HI/LO are not written.
//  FSM states: IDLE, RUN, WRITE.
//  IDLE, ex_divu=1, ex_rt_val!=0: at the edge latch div_a/div_b; state->RUN, cnt=LATENCY-1,
//   div_start=1 for exactly the next cycle.
//  IDLE, ex_divu=1, ex_rt_val==0: no div_start; at the edge hi<=ex_rs_val, lo<=all-ones,
//   dbz<=1; state->WRITE.
//  RUN: cnt decrements each cycle. When cnt==0: hi<=div_result[2W-1:W], lo<=div_result[W-1:0]
//   at the edge; state->WRITE. ex_divu in RUN is ignored (the stall prevents it).
//  WRITE: hilo_we=1 for this single cycle; HI/LO are already visible. Next state is IDLE, or
//   re-accept when ex_divu=1 (same rules as IDLE), giving back-to-back divides.
//  Latency: ex_divu in cycle 0 -> div_start in cycle 1 -> hilo_we and new HI/LO in cycle LATENCY+1.
//   Divide by zero: hilo_we and new HI/LO in cycle 1.
//  stall (combinational) = (id_mf_hi | id_mf_lo | id_divu) & (state==RUN |
//   ((state==IDLE | state==WRITE) & ex_divu)). No stall in WRITE without ex_divu.
//  busy=1 in RUN and WRITE. dbz is cleared only by reset.
//  HI/LO hold their value in all cycles except the capture edge.
// TESTING
//  1 LATENCY=33, 100/7 at cycle 0 -> div_start in cycle 1; hilo_we in cycle 34; hi=2, lo=14; busy 1..34.
//  2 divu then mflo in ID -> stall=1 from cycle 0 through cycle 33; 0 in cycle 34; mflo reads 14.
//  3 divisor 0, dividend 0x1234 -> no div_start; cycle 1: hilo_we=1, hi=0x1234, lo=0xFFFFFFFF, dbz=1.
//  4 second divu in EX during WRITE -> re-accepted; two hilo_we pulses exactly 34 cycles apart.
//  5 rst low in RUN cycle 10 -> state IDLE, hi/lo=0, no hilo_we; a new divu afterwards completes normally.
//  6 unrelated ID instruction during RUN -> stall=0; HI/LO unchanged until the capture edge.

Source files
------------

// File: rtl/divu_sequencer.sv
// rtl/divu_sequencer.sv - DIVU sequencer: operand latch, divider start/latency count, HI/LO capture, ID stall
module divu_sequencer #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 33
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               ex_divu_i,
    input  logic [WIDTH-1:0]   ex_rs_val_i,
    input  logic [WIDTH-1:0]   ex_rt_val_i,
    input  logic               id_mf_hi_i,
    input  logic               id_mf_lo_i,
    input  logic               id_divu_i,
    output logic               div_start_o,
    output logic [WIDTH-1:0]   div_a_o,
    output logic [WIDTH-1:0]   div_b_o,
    input  logic [2*WIDTH-1:0] div_result_i,
    output logic               stall_o,
    output logic               busy_o,
    output logic               hilo_we_o,
    output logic [WIDTH-1:0]   hi_o,
    output logic [WIDTH-1:0]   lo_o,
    output logic               dbz_o
);

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic               div_start_q;
    logic [WIDTH-1:0]   div_a_q;
    logic [WIDTH-1:0]   div_b_q;
    logic               hilo_we_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               dbz_q;
    logic               can_accept;
    logic               id_dep;

    assign can_accept = (state_q == S_IDLE) || (state_q == S_WRITE);
    assign id_dep     = id_mf_hi_i | id_mf_lo_i | id_divu_i;

    // WRITE can take a new DIVU, so a dependent ID instruction must also wait behind an accept.
    assign stall_o = id_dep & ((state_q == S_RUN) | (can_accept & ex_divu_i));
    assign busy_o  = (state_q == S_RUN) || (state_q == S_WRITE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            div_start_q <= 1'b0;
            div_a_q     <= '0;
            div_b_q     <= '0;
            hilo_we_q   <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            dbz_q       <= 1'b0;
        end else begin
            div_start_q <= 1'b0;
            hilo_we_q   <= 1'b0;
            case (state_q)
                S_IDLE, S_WRITE: begin
                    if (ex_divu_i) begin
                        if (ex_rt_val_i != '0) begin
                            div_a_q     <= ex_rs_val_i;
                            div_b_q     <= ex_rt_val_i;
                            cnt_q       <= CW'(LATENCY - 1);
                            div_start_q <= 1'b1;
                            state_q     <= S_RUN;
                        end else begin
                            // Zero divisor never reaches the divider: HI keeps the dividend, LO saturates.
                            hi_q      <= ex_rs_val_i;
                            lo_q      <= '1;
                            dbz_q     <= 1'b1;
                            hilo_we_q <= 1'b1;
                            state_q   <= S_WRITE;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (cnt_q == '0) begin
                        hi_q      <= div_result_i[2*WIDTH-1:WIDTH];
                        lo_q      <= div_result_i[WIDTH-1:0];
                        hilo_we_q <= 1'b1;
                        state_q   <= S_WRITE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign div_start_o = div_start_q;
    assign div_a_o     = div_a_q;
    assign div_b_o     = div_b_q;
    assign hilo_we_o   = hilo_we_q;
    assign hi_o        = hi_q;
    assign lo_o        = lo_q;
    assign dbz_o       = dbz_q;

endmodule

// File: tb/tb_divu_sequencer.sv
// tb/tb_divu_sequencer.sv - scoreboard bench for divu_sequencer with behavioural divider and reference model
module tb_divu_sequencer;

    localparam int W   = 32;
    localparam int LAT = 33;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ex_divu = 1'b0;
    logic [W-1:0]  ex_rs = '0;
    logic [W-1:0]  ex_rt = '0;
    logic          id_hi = 1'b0;
    logic          id_lo = 1'b0;
    logic          id_dv = 1'b0;
    logic          div_start_o;
    logic [W-1:0]  div_a_o;
    logic [W-1:0]  div_b_o;
    logic [2*W-1:0] div_result;
    logic          stall_o;
    logic          busy_o;
    logic          hilo_we_o;
    logic [W-1:0]  hi_o;
    logic [W-1:0]  lo_o;
    logic          dbz_o;

    divu_sequencer #(.WIDTH(W), .LATENCY(LAT)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .ex_divu_i    (ex_divu),
        .ex_rs_val_i  (ex_rs),
        .ex_rt_val_i  (ex_rt),
        .id_mf_hi_i   (id_hi),
        .id_mf_lo_i   (id_lo),
        .id_divu_i    (id_dv),
        .div_start_o  (div_start_o),
        .div_a_o      (div_a_o),
        .div_b_o      (div_b_o),
        .div_result_i (div_result),
        .stall_o      (stall_o),
        .busy_o       (busy_o),
        .hilo_we_o    (hilo_we_o),
        .hi_o         (hi_o),
        .lo_o         (lo_o),
        .dbz_o        (dbz_o)
    );

    always #5 clk = ~clk;

    // Divider stand-in: the quotient/remainder appear only in the cycle LAT after the start pulse.
    logic [W-1:0] da, db;
    logic         dpend;
    int           dleft;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dpend <= 1'b0;
            dleft <= 0;
        end else if (div_start_o) begin
            da    <= div_a_o;
            db    <= div_b_o;
            dpend <= 1'b1;
            dleft <= LAT - 2;
        end else if (dpend && dleft > 0) begin
            dleft <= dleft - 1;
        end
    end
    assign div_result = (dpend && dleft == 0) ? {da % db, da / db} : 64'hBAD0_C0DE_5EED_F00D;

    typedef struct {
        int           cyc;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } exp_t;

    exp_t         sb[$];
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;
    int           wr_cyc = -1;
    int           start_cyc = -1;
    logic [W-1:0] exp_a = '0, exp_b = '0;
    logic [W-1:0] hi_m = '0, lo_m = '0;
    logic         dbz_m = 1'b0;
    logic         exp_stall = 1'b0;
    logic         exp_busy = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input bit ex, input logic [W-1:0] rs, input logic [W-1:0] rt,
                        input bit mh, input bit ml, input bit md);
        bit in_run, in_wr;
        exp_t e;
        @(posedge clk);
        cyc++;
        #1;
        rst_n   = 1'b1;
        ex_divu = ex;
        ex_rs   = rs;
        ex_rt   = rt;
        id_hi   = mh;
        id_lo   = ml;
        id_dv   = md;
        in_run    = (wr_cyc > cyc);
        in_wr     = (wr_cyc == cyc);
        exp_stall = (mh | ml | md) & (in_run | ex);
        exp_busy  = in_run | in_wr;
        if (ex && !in_run) begin
            if (rt != 0) begin
                start_cyc = cyc + 1;
                exp_a     = rs;
                exp_b     = rt;
                wr_cyc    = cyc + LAT + 1;
                e.hi = rs % rt; e.lo = rs / rt; e.dbz = 1'b0;
            end else begin
                wr_cyc = cyc + 1;
                e.hi = rs; e.lo = '1; e.dbz = 1'b1;
            end
            e.cyc = wr_cyc;
            sb.push_back(e);
        end
    endtask

    task automatic reset_cycle();
        @(posedge clk);
        cyc++;
        #1;
        rst_n   = 1'b0;
        ex_divu = 1'b0;
        id_hi   = 1'b0;
        id_lo   = 1'b0;
        id_dv   = 1'b0;
        sb.delete();
        wr_cyc    = -1;
        start_cyc = -1;
        hi_m      = '0;
        lo_m      = '0;
        dbz_m     = 1'b0;
        exp_stall = 1'b0;
        exp_busy  = 1'b0;
    endtask

    task automatic idle(input int n, input bit ml);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, ml, 1'b0);
    endtask

    // Monitor: pops the scoreboard on every hilo_we and checks per-cycle outputs against the model.
    always @(negedge clk) begin
        exp_t e;
        chk("stall", 64'(stall_o), 64'(exp_stall));
        chk("busy", 64'(busy_o), 64'(exp_busy));
        chk("div_start", 64'(div_start_o), 64'(cyc == start_cyc));
        if (cyc == start_cyc) begin
            chk("div_a", 64'(div_a_o), 64'(exp_a));
            chk("div_b", 64'(div_b_o), 64'(exp_b));
        end
        if (hilo_we_o) begin
            if (sb.size() == 0) begin
                chk("hilo_we_unexpected", 64'(hilo_we_o), 64'(0));
            end else begin
                e = sb.pop_front();
                chk("hilo_we_cycle", 64'(cyc), 64'(e.cyc));
                hi_m = e.hi; lo_m = e.lo;
                if (e.dbz) dbz_m = 1'b1;
            end
        end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            chk("hilo_we_missing", 64'(hilo_we_o), 64'(1));
            hi_m = e.hi; lo_m = e.lo;
            if (e.dbz) dbz_m = 1'b1;
        end
        chk("hi", 64'(hi_o), 64'(hi_m));
        chk("lo", 64'(lo_o), 64'(lo_m));
        chk("dbz", 64'(dbz_o), 64'(dbz_m));
    end

    initial begin
        logic [W-1:0] rs, rt;
        int           k;
        reset_cycle();
        reset_cycle();

        // 100/7 with mflo waiting in ID for the whole divide
        step(1'b1, 32'd100, 32'd7, 1'b0, 1'b1, 1'b0);
        idle(36, 1'b1);

        // zero divisor resolved in one cycle
        step(1'b1, 32'h1234, 32'd0, 1'b0, 1'b0, 1'b1);
        idle(3, 1'b0);

        // back-to-back: new divu accepted during WRITE, twice
        step(1'b1, 32'hFFFF_FFFF, 32'd3, 1'b0, 1'b0, 1'b0);
        for (int r = 0; r < 2; r++) begin
            k = 0;
            while (cyc + 1 != wr_cyc && k < 100) begin
                idle(1, 1'b0);
                k++;
            end
            step(1'b1, 32'd1000 + r, 32'd9 + r, 1'b0, 1'b0, 1'b0);
        end
        idle(40, 1'b0);

        // reset in RUN cycle 10 aborts, then a fresh divide completes
        step(1'b1, 32'd77, 32'd5, 1'b0, 1'b0, 1'b0);
        idle(9, 1'b0);
        reset_cycle();
        step(1'b1, 32'hDEAD_BEEF, 32'h0000_1001, 1'b1, 1'b0, 1'b0);
        idle(36, 1'b0);

        // randomized traffic, including ex_divu during RUN and unrelated ID instructions
        for (int i = 0; i < 3000; i++) begin
            rs = $urandom;
            if ($urandom_range(0, 3) == 0) rs = $urandom_range(0, 50);
            case ($urandom_range(0, 7))
                0:       rt = '0;
                1:       rt = 32'd1;
                2, 3:    rt = $urandom_range(1, 20);
                4:       rt = rs;
                default: rt = $urandom;
            endcase
            step($urandom_range(0, 3) == 0, rs, rt,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
        end

        k = 0;
        while (sb.size() != 0 && k < 60) begin
            idle(1, 1'b0);
            k++;
        end
        @(negedge clk);
        #1;
        chk("drain_timeout", 64'(sb.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
